// File: rtl/password_lock_ctrl_pkg.sv
// Shared definitions for the password-lock controller: state encodings, key codes,
// the blank display nibble and the timer width.
package password_lock_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_ENTRY    = 4'd1,
      S_CHECK    = 4'd2,
      S_UNLOCKED = 4'd3,
      S_WRONG    = 4'd4,
      S_LOCKOUT  = 4'd5,
      S_SET_NEW  = 4'd6,
      S_SET_DONE = 4'd7
   } state_t;

   localparam logic [3:0]  KEY_CLR     = 4'hA;
   localparam logic [3:0]  KEY_ENT     = 4'hB;
   localparam logic [3:0]  KEY_CHG     = 4'hC;
   localparam logic [3:0]  BLANK_NIB   = 4'hF;
   localparam logic [15:0] BLANK_ENTRY = {4{BLANK_NIB}};
   localparam int          TMR_W       = 29;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

endpackage

// File: rtl/password_lock_ctrl_if.sv
// Keypad-in / LCD-out bus of the password-lock controller.
interface password_lock_ctrl_if;
   import password_lock_ctrl_pkg::*;

   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] password_in;
   logic [1:0]  o_trials;
   logic [3:0]  o_state;
   logic        unlock;
   logic        alarm;

   modport master (
      output key_valid, key_code,
      input  password_in, o_trials, o_state, unlock, alarm
   );

   modport slave (
      input  key_valid, key_code,
      output password_in, o_trials, o_state, unlock, alarm
   );
endinterface

// File: rtl/password_lock_ctrl_timer.sv
// Load/count-down dwell timer; done is asserted while enabled with the count at zero.
module lock_timer
   import password_lock_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [TMR_W-1:0] load_val_i,
   output logic             done_o
);

   logic [TMR_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/password_lock_ctrl.sv
// Keypad password lock: assembles a 4-digit BCD entry, checks it against the stored
// password and sequences trials, lockout, unlock and password change.
module password_lock_ctrl
   import password_lock_ctrl_pkg::*;
#(
   parameter logic [15:0] DEFAULT_PASS = 16'h1234,
   parameter int unsigned MAX_TRIALS   = 3,
   parameter int unsigned WRONG_CYC    = 50_000_000,
   parameter int unsigned UNLOCK_CYC   = 250_000_000,
   parameter int unsigned LOCKOUT_CYC  = 500_000_000
)
(
   input  logic                 clk,
   input  logic                 rst,
   password_lock_ctrl_if.slave  bus
);

   localparam logic [1:0]       TRIALS_RST = 2'(MAX_TRIALS);
   localparam logic [TMR_W-1:0] WRONG_LD   = TMR_W'(WRONG_CYC - 1);
   localparam logic [TMR_W-1:0] UNLOCK_LD  = TMR_W'(UNLOCK_CYC - 1);
   localparam logic [TMR_W-1:0] LOCKOUT_LD = TMR_W'(LOCKOUT_CYC - 1);

   state_t           state_q, state_d;
   logic [15:0]      entry_q, entry_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [1:0]       trials_q, trials_d;
   logic [15:0]      pass_q, pass_d;
   logic             unlock_q, alarm_q;

   logic             tmr_load, tmr_en, tmr_done;
   logic [TMR_W-1:0] tmr_val;
   logic             key_dig, key_clr, key_ent, key_chg, room;

   assign key_dig = bus.key_valid && is_digit(bus.key_code);
   assign key_clr = bus.key_valid && (bus.key_code == KEY_CLR);
   assign key_ent = bus.key_valid && (bus.key_code == KEY_ENT);
   assign key_chg = bus.key_valid && (bus.key_code == KEY_CHG);
   assign room    = (cnt_q < 3'd4);
   assign tmr_en  = (state_q == S_WRONG) || (state_q == S_LOCKOUT) || (state_q == S_UNLOCKED);

   lock_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .en_i       (tmr_en),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   always_comb begin
      state_d  = state_q;
      entry_d  = entry_q;
      cnt_d    = cnt_q;
      trials_d = trials_q;
      pass_d   = pass_q;
      tmr_load = 1'b0;
      tmr_val  = '0;

      case (state_q)
         S_IDLE: begin
            if (key_dig) begin
               if (room) begin
                  entry_d = {entry_q[11:0], bus.key_code};
                  cnt_d   = cnt_q + 3'd1;
               end
               state_d = S_ENTRY;
            end else if (key_clr) begin
               entry_d = BLANK_ENTRY;
               cnt_d   = '0;
            end
         end
         S_ENTRY: begin
            if (key_dig) begin
               if (room) begin
                  entry_d = {entry_q[11:0], bus.key_code};
                  cnt_d   = cnt_q + 3'd1;
               end
            end else if (key_clr) begin
               entry_d = BLANK_ENTRY;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (key_ent && (cnt_q == 3'd4)) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            entry_d  = BLANK_ENTRY;
            cnt_d    = '0;
            tmr_load = 1'b1;
            if (entry_q == pass_q) begin
               trials_d = TRIALS_RST;
               state_d  = S_UNLOCKED;
               tmr_val  = UNLOCK_LD;
            end else if (trials_q > 2'd1) begin
               trials_d = trials_q - 2'd1;
               state_d  = S_WRONG;
               tmr_val  = WRONG_LD;
            end else begin
               trials_d = 2'd0;
               state_d  = S_LOCKOUT;
               tmr_val  = LOCKOUT_LD;
            end
         end
         // Timer expiry outranks any key arriving in the same cycle.
         S_UNLOCKED: begin
            if (tmr_done) begin
               entry_d = BLANK_ENTRY;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (key_chg) begin
               entry_d = BLANK_ENTRY;
               cnt_d   = '0;
               state_d = S_SET_NEW;
            end else if (key_clr) begin
               entry_d = BLANK_ENTRY;
               cnt_d   = '0;
            end
         end
         S_WRONG: begin
            if (tmr_done) begin
               state_d = S_IDLE;
            end
         end
         S_LOCKOUT: begin
            if (tmr_done) begin
               trials_d = TRIALS_RST;
               state_d  = S_IDLE;
            end
         end
         S_SET_NEW: begin
            if (key_dig) begin
               if (room) begin
                  entry_d = {entry_q[11:0], bus.key_code};
                  cnt_d   = cnt_q + 3'd1;
               end
            end else if (key_clr) begin
               entry_d = BLANK_ENTRY;
               cnt_d   = '0;
            end else if (key_ent && (cnt_q == 3'd4)) begin
               pass_d  = entry_q;
               entry_d = BLANK_ENTRY;
               cnt_d   = '0;
               state_d = S_SET_DONE;
            end
         end
         S_SET_DONE: begin
            tmr_load = 1'b1;
            tmr_val  = UNLOCK_LD;
            state_d  = S_UNLOCKED;
         end
         default: begin
            entry_d = BLANK_ENTRY;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         entry_q  <= BLANK_ENTRY;
         cnt_q    <= '0;
         trials_q <= TRIALS_RST;
         pass_q   <= DEFAULT_PASS;
         unlock_q <= 1'b0;
         alarm_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         entry_q  <= entry_d;
         cnt_q    <= cnt_d;
         trials_q <= trials_d;
         pass_q   <= pass_d;
         unlock_q <= (state_d == S_UNLOCKED);
         alarm_q  <= (state_d == S_LOCKOUT);
      end
   end

   assign bus.password_in = entry_q;
   assign bus.o_trials    = trials_q;
   assign bus.o_state     = state_q;
   assign bus.unlock      = unlock_q;
   assign bus.alarm       = alarm_q;

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Scoreboard bench for password_lock_ctrl with short dwell times.
module tb_password_lock_ctrl;
   import password_lock_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   password_lock_ctrl_if bus_if();

   password_lock_ctrl #(
      .DEFAULT_PASS (16'h1234),
      .MAX_TRIALS   (3),
      .WRONG_CYC    (8),
      .UNLOCK_CYC   (20),
      .LOCKOUT_CYC  (30)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      int          due;
      string       nm;
      logic [3:0]  st;
      logic [15:0] pw;
      logic [1:0]  tr;
      bit          chkpw;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_at(input int due, input string nm, input logic [3:0] st,
                          input logic [15:0] pw, input logic [1:0] tr, input bit chkpw);
      exp_t e;
      int   i;
      e.due = due; e.nm = nm; e.st = st; e.pw = pw; e.tr = tr; e.chkpw = chkpw;
      i = sb.size();
      while (i > 0 && sb[i-1].due > due) i--;
      sb.insert(i, e);
   endtask

   task automatic push(input int dly, input string nm, input logic [3:0] st,
                       input logic [15:0] pw, input logic [1:0] tr, input bit chkpw);
      push_at(cyc + dly, nm, st, pw, tr, chkpw);
   endtask

   task automatic key(input logic [3:0] k);
      @(negedge clk);
      bus_if.key_valid = 1'b1;
      bus_if.key_code  = k;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus_if.key_valid = 1'b0;
         bus_if.key_code  = 4'h0;
      end
   endtask

   task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, output int bcyc);
      key(a); key(b); key(c); key(d); key(KEY_ENT);
      bcyc = cyc;
   endtask

   task automatic try5555(input logic [1:0] tr, output int bcyc);
      key(4'd5); push(1, "w_d1", 4'd1, 16'hFFF5, tr, 1'b1);
      key(4'd5); push(1, "w_d2", 4'd1, 16'hFF55, tr, 1'b1);
      key(4'd5); push(1, "w_d3", 4'd1, 16'hF555, tr, 1'b1);
      key(4'd5); push(1, "w_d4", 4'd1, 16'h5555, tr, 1'b1);
      key(KEY_ENT);
      bcyc = cyc;
      push(1, "w_check", 4'd2, 16'h5555, tr, 1'b1);
   endtask

   // Monitor: pops every expectation whose cycle has come and compares the bus.
   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (e.due < cyc) begin
               bad++;
               $display("FAIL %s: stale expectation due=%0d now=%0d", e.nm, e.due, cyc);
            end else if (bus_if.o_state !== e.st || bus_if.o_trials !== e.tr ||
                         bus_if.unlock !== (e.st == 4'd3) || bus_if.alarm !== (e.st == 4'd5) ||
                         (e.chkpw && bus_if.password_in !== e.pw)) begin
               bad++;
               $display("FAIL %s @%0d: got state=%0d pw=%h trials=%0d unlock=%b alarm=%b, want state=%0d pw=%h trials=%0d",
                        e.nm, cyc, bus_if.o_state, bus_if.password_in, bus_if.o_trials,
                        bus_if.unlock, bus_if.alarm, e.st, e.pw, e.tr);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int b;
      bus_if.key_valid = 1'b0;
      bus_if.key_code  = 4'h0;

      // Reset values
      idle(3);
      push(1, "reset", 4'd0, 16'hFFFF, 2'd3, 1'b1);
      idle(1);
      rst = 1'b0;

      // Correct entry and auto-relock
      key(4'd1); push(1, "e_d1", 4'd1, 16'hFFF1, 2'd3, 1'b1);
      key(4'd2); push(1, "e_d2", 4'd1, 16'hFF12, 2'd3, 1'b1);
      key(4'd3); push(1, "e_d3", 4'd1, 16'hF123, 2'd3, 1'b1);
      key(4'd4); push(1, "e_d4", 4'd1, 16'h1234, 2'd3, 1'b1);
      key(KEY_ENT);
      push(1,  "e_check",    4'd2, 16'h1234, 2'd3, 1'b1);
      push(2,  "e_unlocked", 4'd3, 16'hFFFF, 2'd3, 1'b1);
      push(21, "e_unl_hold", 4'd3, 16'hFFFF, 2'd3, 1'b1);
      push(22, "e_relock",   4'd0, 16'hFFFF, 2'd3, 1'b1);
      idle(24);

      // Three wrong entries into lockout
      try5555(2'd3, b);
      push_at(b + 2,  "w1_wrong", 4'd4, 16'hFFFF, 2'd2, 1'b1);
      push_at(b + 9,  "w1_hold",  4'd4, 16'hFFFF, 2'd2, 1'b1);
      push_at(b + 10, "w1_exit",  4'd0, 16'hFFFF, 2'd2, 1'b1);
      idle(11);
      try5555(2'd2, b);
      push_at(b + 2,  "w2_wrong", 4'd4, 16'hFFFF, 2'd1, 1'b1);
      push_at(b + 10, "w2_exit",  4'd0, 16'hFFFF, 2'd1, 1'b1);
      idle(11);
      try5555(2'd1, b);
      push_at(b + 2, "lockout", 4'd5, 16'hFFFF, 2'd0, 1'b1);
      key(4'd1);    push(1, "lk_ign1", 4'd5, 16'hFFFF, 2'd0, 1'b1);
      key(4'd2);    push(1, "lk_ign2", 4'd5, 16'hFFFF, 2'd0, 1'b1);
      key(KEY_ENT); push(1, "lk_ignB", 4'd5, 16'hFFFF, 2'd0, 1'b1);
      key(KEY_CLR); push(1, "lk_ignA", 4'd5, 16'hFFFF, 2'd0, 1'b1);
      key(KEY_CHG); push(1, "lk_ignC", 4'd5, 16'hFFFF, 2'd0, 1'b1);
      push_at(b + 31, "lk_hold", 4'd5, 16'hFFFF, 2'd0, 1'b1);
      push_at(b + 32, "lk_exit", 4'd0, 16'hFFFF, 2'd3, 1'b1);
      idle(b + 33 - cyc);

      // Short and overlong entry, undefined code, clear
      key(4'd1);    push(1, "s_d1",   4'd1, 16'hFFF1, 2'd3, 1'b1);
      key(4'd2);    push(1, "s_d2",   4'd1, 16'hFF12, 2'd3, 1'b1);
      key(4'hE);    push(1, "s_undef",4'd1, 16'hFF12, 2'd3, 1'b1);
      key(KEY_ENT); push(1, "s_short",4'd1, 16'hFF12, 2'd3, 1'b1);
      key(4'd3);    push(1, "s_d3",   4'd1, 16'hF123, 2'd3, 1'b1);
      key(4'd4);    push(1, "s_d4",   4'd1, 16'h1234, 2'd3, 1'b1);
      key(4'd5);    push(1, "s_d5drop",4'd1,16'h1234, 2'd3, 1'b1);
      key(KEY_CLR); push(1, "s_clear",4'd0, 16'hFFFF, 2'd3, 1'b1);
      idle(2);

      // Password change to 9876
      enter(4'd1, 4'd2, 4'd3, 4'd4, b);
      push_at(b + 2, "p_unl", 4'd3, 16'hFFFF, 2'd3, 1'b1);
      idle(1);
      key(KEY_CHG); push(1, "p_setnew", 4'd6, 16'hFFFF, 2'd3, 1'b1);
      key(4'd9);    push(1, "p_d9",     4'd6, 16'hFFF9, 2'd3, 1'b1);
      key(4'd8);    push(1, "p_d8",     4'd6, 16'hFF98, 2'd3, 1'b1);
      key(KEY_CLR); push(1, "p_clr",    4'd6, 16'hFFFF, 2'd3, 1'b1);
      key(4'd9);    push(1, "p_e9",     4'd6, 16'hFFF9, 2'd3, 1'b1);
      key(4'd8);    push(1, "p_e8",     4'd6, 16'hFF98, 2'd3, 1'b1);
      key(4'd7);    push(1, "p_e7",     4'd6, 16'hF987, 2'd3, 1'b1);
      key(4'd6);    push(1, "p_e6",     4'd6, 16'h9876, 2'd3, 1'b1);
      key(KEY_ENT);
      push(1,  "p_setdone",  4'd7, 16'hFFFF, 2'd3, 1'b0);
      push(2,  "p_unl_new",  4'd3, 16'hFFFF, 2'd3, 1'b0);
      push(21, "p_unl_hold", 4'd3, 16'hFFFF, 2'd3, 1'b0);
      push(22, "p_relock",   4'd0, 16'hFFFF, 2'd3, 1'b1);
      idle(24);
      enter(4'd1, 4'd2, 4'd3, 4'd4, b);
      push_at(b + 1, "p_old_chk",   4'd2, 16'h1234, 2'd3, 1'b1);
      push_at(b + 2, "p_old_wrong", 4'd4, 16'hFFFF, 2'd2, 1'b1);
      idle(8);
      // Digit strobe sampled on the WRONG expiry edge must be dropped
      key(4'd7);    push(1, "t_expiry_key", 4'd0, 16'hFFFF, 2'd2, 1'b1);
      key(4'd8);    push(1, "t_after_exp",  4'd1, 16'hFFF8, 2'd2, 1'b1);
      key(KEY_CLR); push(1, "t_clr_idle",   4'd0, 16'hFFFF, 2'd2, 1'b1);
      idle(1);
      enter(4'd9, 4'd8, 4'd7, 4'd6, b);
      push_at(b + 1, "p_new_chk", 4'd2, 16'h9876, 2'd2, 1'b1);
      push_at(b + 2, "p_new_unl", 4'd3, 16'hFFFF, 2'd3, 1'b1);
      idle(2);

      // Reset after password change restores the default password
      @(negedge clk);
      rst = 1'b1;
      push(1, "r_unl", 4'd0, 16'hFFFF, 2'd3, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      enter(4'd1, 4'd2, 4'd3, 4'd4, b);
      push_at(b + 2, "r_default", 4'd3, 16'hFFFF, 2'd3, 1'b1);
      idle(1);
      key(KEY_CHG); push(1, "r_setnew", 4'd6, 16'hFFFF, 2'd3, 1'b1);
      key(4'd9);    push(1, "r_sn_d9",  4'd6, 16'hFFF9, 2'd3, 1'b1);
      key(4'd8);
      rst = 1'b1;
      push(1, "r_in_setnew", 4'd0, 16'hFFFF, 2'd3, 1'b1);
      idle(1);
      rst = 1'b0;

      // Reset during lockout, with a simultaneous key strobe
      try5555(2'd3, b);
      push_at(b + 2, "rl_w1", 4'd4, 16'hFFFF, 2'd2, 1'b1);
      idle(10);
      try5555(2'd2, b);
      push_at(b + 2, "rl_w2", 4'd4, 16'hFFFF, 2'd1, 1'b1);
      idle(10);
      try5555(2'd1, b);
      push_at(b + 2, "rl_lock", 4'd5, 16'hFFFF, 2'd0, 1'b1);
      idle(5);
      key(4'd5);
      rst = 1'b1;
      push(1, "rl_reset", 4'd0, 16'hFFFF, 2'd3, 1'b1);
      idle(1);
      rst = 1'b0;
      enter(4'd1, 4'd2, 4'd3, 4'd4, b);
      push_at(b + 2, "rl_unlock", 4'd3, 16'hFFFF, 2'd3, 1'b1);
      idle(2);
      @(negedge clk);
      rst = 1'b1;
      push(1, "rl_reset2", 4'd0, 16'hFFFF, 2'd3, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // Unused state code recovers to IDLE
      @(negedge clk);
      force dut.state_q = state_t'(4'd9);
      #1;
      release dut.state_q;
      push(1, "bad_state", 4'd0, 16'hFFFF, 2'd3, 1'b1);
      idle(2);

      for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
